// File: rtl/window_scanner_pkg.sv
// Shared types and width helpers for the window scanner: FSM state encoding,
// width derivation and the default-geometry origin record.
package window_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int unsigned pos_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int unsigned IMG_WIDTH_MAX_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_MAX_DEF = 480;
  localparam int unsigned STEP_MAX_DEF       = 15;

  localparam int unsigned POS_X_W = pos_width(IMG_WIDTH_MAX_DEF);
  localparam int unsigned POS_Y_W = pos_width(IMG_HEIGHT_MAX_DEF);

  typedef struct packed {
    logic [POS_X_W-1:0] x;
    logic [POS_Y_W-1:0] y;
  } win_pos_t;

endpackage

// File: rtl/window_scanner_if.sv
// Window-origin stream towards the window fetch stage: valid/ready plus the
// origin payload and frame boundary flags.
interface window_scanner_if #(
  parameter int unsigned W_X = 10,
  parameter int unsigned W_Y = 9
);

  logic           win_valid;
  logic           win_ready;
  logic [W_X-1:0] win_x;
  logic [W_Y-1:0] win_y;
  logic           win_first;
  logic           win_last;

  modport master (
    output win_valid, win_x, win_y, win_first, win_last,
    input  win_ready
  );

  modport slave (
    input  win_valid, win_x, win_y, win_first, win_last,
    output win_ready
  );

endinterface

// File: rtl/window_scanner_axis_stepper.sv
// One scan axis: holds position, step and inclusive limit; wrap_o flags that
// the next step would pass the limit.
module axis_stepper #(
  parameter int unsigned W   = 10,
  parameter int unsigned W_S = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [W_S-1:0] step_i,
  input  logic [W-1:0]   lim_i,
  input  logic           advance_i,
  output logic [W-1:0]   pos_o,
  output logic           wrap_o
);

  logic [W-1:0]   pos_q, pos_d;
  logic [W_S-1:0] step_q;
  logic [W-1:0]   lim_q;
  logic [W:0]     next_pos;

  // One extra bit so pos+step never aliases back below the limit.
  assign next_pos = {1'b0, pos_q} + (W+1)'(step_q);
  assign wrap_o   = next_pos > {1'b0, lim_q};
  assign pos_o    = pos_q;

  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = '0;
    end else if (advance_i) begin
      pos_d = wrap_o ? '0 : next_pos[W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      step_q <= '0;
      lim_q  <= '0;
    end else begin
      pos_q <= pos_d;
      if (load_i) begin
        step_q <= step_i;
        lim_q  <= lim_i;
      end
    end
  end

endmodule

// File: rtl/window_scanner.sv
// Run-time configurable detection-window origin generator: latches frame
// geometry on start and streams every origin in raster order.
module window_scanner
  import window_scanner_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH_MAX  = IMG_WIDTH_MAX_DEF,
  parameter  int unsigned IMG_HEIGHT_MAX = IMG_HEIGHT_MAX_DEF,
  parameter  int unsigned WIN_W          = 24,
  parameter  int unsigned WIN_H          = 24,
  parameter  int unsigned STEP_MAX       = STEP_MAX_DEF,
  localparam int unsigned W_X            = pos_width(IMG_WIDTH_MAX),
  localparam int unsigned W_Y            = pos_width(IMG_HEIGHT_MAX),
  localparam int unsigned W_S            = pos_width(STEP_MAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [W_X-1:0]           cfg_width_i,
  input  logic [W_Y-1:0]           cfg_height_i,
  input  logic [W_S-1:0]           cfg_step_x_i,
  input  logic [W_S-1:0]           cfg_step_y_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cfg_err_o,
  window_scanner_if.master         win_if
);

  scan_state_t    state_q, state_d;
  logic           done_q, done_d;
  logic           cfg_err_q, cfg_err_d;
  logic           load, adv_x, adv_y;
  logic           x_wrap, y_wrap;
  logic           cfg_ok, scanning, is_last, xfer;
  logic [W_X-1:0] x_pos, x_lim;
  logic [W_Y-1:0] y_pos, y_lim;
  logic [W_S-1:0] step_x_eff, step_y_eff;

  assign cfg_ok     = (cfg_width_i >= W_X'(WIN_W)) && (cfg_height_i >= W_Y'(WIN_H));
  assign x_lim      = cfg_width_i - W_X'(WIN_W);
  assign y_lim      = cfg_height_i - W_Y'(WIN_H);
  // A zero step would never advance; treat it as the finest grid.
  assign step_x_eff = (cfg_step_x_i == '0) ? W_S'(1) : cfg_step_x_i;
  assign step_y_eff = (cfg_step_y_i == '0) ? W_S'(1) : cfg_step_y_i;

  assign scanning = (state_q == SCAN);
  assign is_last  = scanning && x_wrap && y_wrap;
  assign xfer     = scanning && win_if.win_ready;

  axis_stepper #(.W(W_X), .W_S(W_S)) u_x_axis (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step_x_eff),
    .lim_i     (x_lim),
    .advance_i (adv_x),
    .pos_o     (x_pos),
    .wrap_o    (x_wrap)
  );

  axis_stepper #(.W(W_Y), .W_S(W_S)) u_y_axis (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step_y_eff),
    .lim_i     (y_lim),
    .advance_i (adv_y),
    .pos_o     (y_pos),
    .wrap_o    (y_wrap)
  );

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    adv_x     = 1'b0;
    adv_y     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = SCAN;
          end else begin
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (abort_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (xfer) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            adv_x = 1'b1;
            adv_y = x_wrap;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy_o    = scanning;
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;

  // Origin (0,0) is visited exactly once per frame, so it identifies the first.
  assign win_if.win_valid = scanning;
  assign win_if.win_x     = x_pos;
  assign win_if.win_y     = y_pos;
  assign win_if.win_first = scanning && (x_pos == '0) && (y_pos == '0);
  assign win_if.win_last  = is_last;

endmodule

// File: tb/tb_window_scanner.sv
// Self-checking bench for window_scanner: directed and randomized frames
// compared against a raster-order origin list built from the frame geometry.
module tb_window_scanner;
  import window_scanner_pkg::*;

  localparam int WIN = 24;
  localparam int MAX_CYC = 5000;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i, abort_i;
  logic [POS_X_W-1:0]  cfg_width_i;
  logic [POS_Y_W-1:0]  cfg_height_i;
  logic [3:0]          cfg_step_x_i, cfg_step_y_i;
  logic                busy_o, done_o, cfg_err_o;

  int checks = 0;
  int errors = 0;

  window_scanner_if #(.W_X(POS_X_W), .W_Y(POS_Y_W)) wif ();

  window_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .cfg_width_i  (cfg_width_i),
    .cfg_height_i (cfg_height_i),
    .cfg_step_x_i (cfg_step_x_i),
    .cfg_step_y_i (cfg_step_y_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cfg_err_o    (cfg_err_o),
    .win_if       (wif.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] payload();
    return {wif.win_x, wif.win_y, wif.win_first, wif.win_last};
  endfunction

  // Runs one frame from the current post-edge instant. abort_after>0 aborts
  // once that many origins have been accepted.
  task automatic run_frame(input int w, input int h, input int sx, input int sy,
                           input bit stall, input int abort_after);
    win_pos_t    q[$];
    win_pos_t    e;
    int          ex, ey, idx, cyc;
    bit          ended, prev_stall;
    logic [20:0] cur, prev;

    ex = (sx == 0) ? 1 : sx;
    ey = (sy == 0) ? 1 : sy;
    if (w >= WIN && h >= WIN) begin
      for (int y = 0; y <= h - WIN; y += ey) begin
        for (int x = 0; x <= w - WIN; x += ex) begin
          e.x = POS_X_W'(x);
          e.y = POS_Y_W'(y);
          q.push_back(e);
        end
      end
    end

    cfg_width_i  = POS_X_W'(w);
    cfg_height_i = POS_Y_W'(h);
    cfg_step_x_i = 4'(sx);
    cfg_step_y_i = 4'(sy);
    start_i      = 1'b1;
    wif.win_ready = 1'b0;
    tick();
    start_i = 1'b0;

    if (q.size() == 0) begin
      check("err_flags", {wif.win_valid, busy_o, done_o, cfg_err_o}, 4'b0011);
      tick();
      check("err_pulse_end", {wif.win_valid, done_o, cfg_err_o}, 3'b000);
      return;
    end

    idx = 0; cyc = 0; ended = 0; prev_stall = 0; prev = '0;
    forever begin
      if (ended) begin
        check("end_flags", {wif.win_valid, busy_o, done_o, cfg_err_o}, 4'b0010);
        break;
      end
      if (cyc >= MAX_CYC) begin
        check("timeout", 1, 0);
        break;
      end
      cyc++;
      check("scan_flags", {wif.win_valid, busy_o, done_o}, 3'b110);
      cur = payload();
      if (prev_stall) check("stall_stable", cur, prev);
      if (idx < q.size())
        check("origin", cur, {q[idx].x, q[idx].y, idx == 0, idx == q.size() - 1});
      if (abort_after > 0 && idx == abort_after) begin
        abort_i       = 1'b1;
        wif.win_ready = 1'b0;
        ended         = 1;
      end else begin
        wif.win_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall) begin
          start_i     = 1'($urandom_range(0, 1));
          cfg_width_i = POS_X_W'($urandom_range(0, 640));
        end
        if (wif.win_ready) begin
          ended = (idx == q.size() - 1);
          idx++;
        end
      end
      prev_stall = !wif.win_ready;
      prev       = cur;
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
    end
    wif.win_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; wif.win_ready = 1'b0;
    cfg_width_i = '0; cfg_height_i = '0; cfg_step_x_i = '0; cfg_step_y_i = '0;
    tick();
    tick();
    check("reset_state", {busy_o, done_o, cfg_err_o, wif.win_valid, payload()}, '0);
    rst = 1'b0;
    tick();

    // start and abort together in IDLE: abort wins, nothing happens
    cfg_width_i = 41; cfg_height_i = 50; cfg_step_x_i = 1; cfg_step_y_i = 1;
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("start_abort_idle", {wif.win_valid, busy_o, done_o}, 3'b000);

    run_frame(41, 50, 1, 1, 0, 0);
    run_frame(41, 50, 4, 4, 0, 0);
    run_frame(24, 24, 1, 1, 0, 0);
    run_frame(41, 50, 1, 1, 1, 0);
    run_frame(20, 50, 1, 1, 0, 0);

    // synchronous reset mid-scan: back to reset values, no done pulse
    cfg_width_i = 41; cfg_height_i = 50; cfg_step_x_i = 1; cfg_step_y_i = 1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0; wif.win_ready = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; wif.win_ready = 1'b0;
    check("mid_scan_reset", {busy_o, done_o, cfg_err_o, wif.win_valid, payload()}, '0);
    tick();
    check("reset_no_done", {busy_o, done_o}, 2'b00);

    run_frame(41, 50, 1, 1, 0, 10);
    run_frame(41, 50, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      run_frame(int'($urandom_range(24, 70)), int'($urandom_range(24, 60)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
